// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM encodings and ALU_Control opcodes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

  localparam int ALU_CTRL_W = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 6'b000000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 6'b001000;
  localparam logic [ALU_CTRL_W-1:0] ALU_BEQ = 6'b010000;
  localparam logic [ALU_CTRL_W-1:0] ALU_BLT = 6'b010100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at (last_grant+1) mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  // Outer loop walks priority offsets, inner loop finds the requester at that offset;
  // both indices are loop constants so every select is static.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (i == (int'(last_grant) + 1 + k) % NUM_REQ)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          grant_id = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3,
  parameter int ID_W       = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [6*NUM_REQ-1:0]          req_alu_control,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_A,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_B,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [5:0]                    ALU_Control,
  output logic [DATA_WIDTH-1:0]         operand_A,
  output logic [DATA_WIDTH-1:0]         operand_B,
  input  logic [DATA_WIDTH-1:0]         ALU_result,
  input  logic                          zero,
  input  logic                          branch,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_zero,
  output logic                          resp_branch
);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [5:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]       resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                  resp_zero_q, resp_zero_d;
  logic                  resp_branch_q, resp_branch_d;

  logic [NUM_REQ-1:0]    req_eff, gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  any, can_accept, accept;

`ifdef ALU_ARB_LOCK_EN
  logic                  lock_q, lock_d;
  logic [ID_W-1:0]       lock_id_q, lock_id_d;

  // While locked only the lock owner is visible to the picker.
  always_comb begin
    req_eff = req_valid;
    if (lock_q) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (lock_id_q != ID_W'(i)) req_eff[i] = 1'b0;
    end
  end
`else
  assign req_eff = req_valid;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req        (req_eff),
    .last_grant (last_q),
    .grant      (gnt),
    .grant_id   (gnt_id),
    .any        (any)
  );

  // Gating with reset keeps req_ready low while reset is held.
  assign can_accept = reset && ((state_q == S_IDLE) || (state_q == S_RESP && resp_ready));
  assign accept     = can_accept && any;
  assign req_ready  = accept ? gnt : '0;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    ctrl_d        = ctrl_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_branch_d = resp_branch_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d        = lock_q;
    lock_id_d     = lock_id_q;
`endif
    if (accept) begin
      last_d = gnt_id;
      id_d   = gnt_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          ctrl_d = req_alu_control[6*i +: 6];
          opa_d  = req_operand_A[DATA_WIDTH*i +: DATA_WIDTH];
          opb_d  = req_operand_B[DATA_WIDTH*i +: DATA_WIDTH];
`ifdef ALU_ARB_LOCK_EN
          lock_d = req_lock[i];
`endif
        end
      end
`ifdef ALU_ARB_LOCK_EN
      lock_id_d = gnt_id;
`endif
    end
    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: begin
        state_d       = S_RESP;
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_result_d = ALU_result;
        resp_zero_d   = zero;
        resp_branch_d = branch;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = accept ? S_EXEC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      ctrl_q        <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_branch_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_q        <= 1'b0;
      lock_id_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      id_q          <= id_d;
      ctrl_q        <= ctrl_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_branch_q <= resp_branch_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q        <= lock_d;
      lock_id_q     <= lock_id_d;
`endif
    end
  end

  assign ALU_Control = ctrl_q;
  assign operand_A   = opa_q;
  assign operand_B   = opb_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_branch = resp_branch_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed responses, a monitor pops them.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [6*N-1:0]    req_alu_control = '0;
  logic [DW*N-1:0]   req_operand_A = '0;
  logic [DW*N-1:0]   req_operand_B = '0;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]      req_lock = '0;
`endif
  logic [5:0]        ALU_Control;
  logic [DW-1:0]     operand_A, operand_B, ALU_result;
  logic              zero, branch;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_result;
  logic              resp_zero, resp_branch;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_alu_control (req_alu_control),
    .req_operand_A   (req_operand_A),
    .req_operand_B   (req_operand_B),
`ifdef ALU_ARB_LOCK_EN
    .req_lock        (req_lock),
`endif
    .ALU_Control     (ALU_Control),
    .operand_A       (operand_A),
    .operand_B       (operand_B),
    .ALU_result      (ALU_result),
    .zero            (zero),
    .branch          (branch),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_result     (resp_result),
    .resp_zero       (resp_zero),
    .resp_branch     (resp_branch)
  );

  always #5 clock = ~clock;

  // Stand-in for the external combinational ALU.
  always_comb begin
    ALU_result = '0;
    branch     = 1'b0;
    case (ALU_Control)
      ALU_ADD: ALU_result = operand_A + operand_B;
      ALU_SUB: ALU_result = operand_A - operand_B;
      ALU_BEQ: begin ALU_result = {31'd0, operand_A == operand_B}; branch = (operand_A == operand_B); end
      ALU_BLT: begin
        ALU_result = {31'd0, $signed(operand_A) < $signed(operand_B)};
        branch     = ($signed(operand_A) < $signed(operand_B));
      end
      default: ALU_result = '0;
    endcase
    zero = (ALU_result == '0);
  end

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] res;
    logic          z;
    logic          br;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  // Per-requester vectors used by the multi-requester tests, with hand-computed results.
  logic [5:0]  t_op  [N] = '{ALU_ADD, ALU_SUB, ALU_BLT};
  logic [31:0] t_a   [N] = '{32'd1, 32'd4, 32'd3};
  logic [31:0] t_b   [N] = '{32'd2, 32'd4, 32'd9};
  logic [31:0] t_res [N] = '{32'd3, 32'd0, 32'd1};
  logic        t_z   [N] = '{1'b0, 1'b1, 1'b0};
  logic        t_br  [N] = '{1'b0, 1'b0, 1'b1};

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    tot_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic set_op(int r, logic [5:0] c, logic [31:0] a, logic [31:0] b);
    req_alu_control[6*r +: 6] = c;
    req_operand_A[DW*r +: DW] = a;
    req_operand_B[DW*r +: DW] = b;
  endtask

  task automatic load_table();
    for (int r = 0; r < N; r++) set_op(r, t_op[r], t_a[r], t_b[r]);
  endtask

  task automatic push(int id, logic [31:0] res, logic z, logic br);
    exp_t e;
    e.id = IW'(id); e.res = res; e.z = z; e.br = br;
    sb.push_back(e);
  endtask

  task automatic push_tab(int id);
    push(id, t_res[id], t_z[id], t_br[id]);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_resp: got id %0d result %0h want no response", resp_id, resp_result);
        end else begin
          e = sb.pop_front();
          check("resp", 64'({resp_id, resp_result, resp_zero, resp_branch}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    // Reset state
    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_fields", 64'({resp_id, resp_zero, resp_branch}), 64'd0);
    check("rst_resp_result", 64'(resp_result), 64'd0);
    check("rst_alu_ctrl", 64'(ALU_Control), 64'd0);
    check("rst_operands", {operand_A, operand_B}, 64'd0);
    step(); reset = 1'b1;

    // 1: single ADD, latency 2
    set_op(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 3'b001; resp_ready = 1'b1;
    @(negedge clock);
    check("t1_req_ready", 64'(req_ready), 64'b001);
    if (req_ready != 0) push(0, 32'd12, 1'b0, 1'b0);
    step(); req_valid = '0;
    @(negedge clock);
    check("t1_exec_no_valid", 64'(resp_valid), 64'd0);
    step();
    @(negedge clock);
    check("t1_latency_valid", 64'(resp_valid), 64'd1);
    step();
    drain("t1_drain");

    // 2: all requesters valid from reset, order 0,1,2,0,1,2
    reset = 1'b0; step(); reset = 1'b1;
    load_table();
    req_valid = 3'b111; resp_ready = 1'b1; ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (req_ready != 0) begin
        check("t2_grant", 64'(req_ready), 64'(3'b001 << (ng % 3)));
        push_tab(ng % 3);
        ng++;
      end
      step();
    end
    req_valid = '0;
    check("t2_grant_count", 64'(ng), 64'd6);
    drain("t2_drain");

    // 3: BEQ held under backpressure
    set_op(0, ALU_BEQ, 32'd9, 32'd9);
    req_valid = 3'b001; resp_ready = 1'b0;
    @(negedge clock);
    check("t3_req_ready", 64'(req_ready), 64'b001);
    if (req_ready != 0) push(0, 32'd1, 1'b0, 1'b1);
    step(); req_valid = 3'b110;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t3_ready_low", 64'(req_ready), 64'd0);
      if (c >= 1) check("t3_held", 64'({resp_valid, resp_result, resp_branch}), {31'd0, 1'b1, 32'd1, 1'b1});
      step();
    end
    resp_ready = 1'b1; req_valid = '0;
    drain("t3_drain");

    // 4: reset during EXEC drops the op
    set_op(1, ALU_SUB, 32'd3, 32'd3);
    req_valid = 3'b010;
    @(negedge clock);
    check("t4_req_ready", 64'(req_ready), 64'b010);
    step(); req_valid = '0;
    #2 reset = 1'b0;
    @(negedge clock);
    check("t4_rst_outs", 64'({req_ready, resp_valid, resp_id, resp_zero, resp_branch, ALU_Control}), 64'd0);
    check("t4_rst_data", 64'({resp_result, operand_A | operand_B}), 64'd0);
    step(); reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("t4_no_resp", 64'(resp_valid), 64'd0);
      step();
    end
    load_table();
    req_valid = 3'b111;
    @(negedge clock);
    check("t4_grant_after_rst", 64'(req_ready), 64'b001);
    if (req_ready != 0) push_tab(0);
    step(); req_valid = '0;
    drain("t4_drain");

`ifdef ALU_ARB_LOCK_EN
    // 5: lock holds the grant on requester 1
    req_valid = 3'b111; req_lock = 3'b010;
    @(negedge clock);
    check("t5_lock_grant", 64'(req_ready), 64'b010);
    if (req_ready != 0) push_tab(1);
    step(); req_lock = '0;
    @(negedge clock); step();
    @(negedge clock);
    check("t5_locked_regrant", 64'(req_ready), 64'b010);
    if (req_ready != 0) push_tab(1);
    step();
    @(negedge clock); step();
    @(negedge clock);
    check("t5_after_release", 64'(req_ready), 64'b100);
    if (req_ready != 0) push_tab(2);
    step(); req_valid = '0;
    drain("t5_drain");
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
